// File: rtl/m_dm_store_buffer.sv
// Store buffer between M-stage byte-enable generator and data memory.
// Optional STORE_MERGE_EN: same-word pushes merge into the newest entry.
module m_dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_byteen,
  output logic        st_ready,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  output logic        empty
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [29:0]      e_addr [DEPTH];
  logic [31:0]      e_data [DEPTH];
  logic [3:0]       e_be   [DEPTH];
  logic [PTR_W-1:0] head, tail, newest;
  logic [PTR_W:0]   count, count_nx;
  logic [PTR_W-1:0] off [DEPTH];
  logic             full, do_write, do_alloc;
  logic             do_merge, do_pop, merge_ok;
  logic             unused_lsb;

  assign unused_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign newest = tail - PTR_W'(1);

`ifdef STORE_MERGE_EN
  // newest entry is mergeable unless it is the one on the bus
  assign merge_ok = !empty
                 && (e_addr[newest] == st_addr[31:2])
                 && !(mem_req && (newest == head));
`else
  assign merge_ok = 1'b0;
`endif

  assign st_ready = !full || merge_ok;
  assign do_write = st_valid && (st_byteen != 4'b0000);
  assign do_merge = do_write && merge_ok;
  assign do_alloc = do_write && !full && !merge_ok;
  assign do_pop   = mem_req && mem_ack;
  assign count_nx = count
                  + (PTR_W+1)'(do_alloc)
                  - (PTR_W+1)'(do_pop);

  assign mem_addr   = mem_req ? {e_addr[head], 2'b00} : '0;
  assign mem_wdata  = mem_req ? e_data[head] : '0;
  assign mem_byteen = mem_req ? e_be[head] : '0;

  // load hit: word compare against every occupied slot
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = PTR_W'(i) - head;
      if (({1'b0, off[i]} < count)
          && (e_addr[i] == ld_addr[31:2]))
        ld_hit = 1'b1;
    end
  end

  // entry storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_be[i]   <= '0;
      end
    end else begin
      if (do_alloc) begin
        e_addr[tail] <= st_addr[31:2];
        e_data[tail] <= st_wdata;
        e_be[tail]   <= st_byteen;
        tail         <= tail + PTR_W'(1);
      end
      if (do_merge) begin
        for (int b = 0; b < 4; b++)
          if (st_byteen[b])
            e_data[newest][8*b +: 8] <= st_wdata[8*b +: 8];
        e_be[newest] <= e_be[newest] | st_byteen;
      end
      if (do_pop)
        head <= head + PTR_W'(1);
      count <= count_nx;
    end
  end

  // drain FSM: request held while any entry is pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (count_nx != '0) begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: if (do_pop && (count_nx == '0)) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_dm_store_buffer.sv
// Bench for m_dm_store_buffer: directed steps plus random traffic
// checked against a queue-based model of the store buffer.
module tb_m_dm_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_wdata, ld_addr;
  logic [3:0]  st_byteen;
  logic        st_ready, ld_hit, mem_req, mem_ack, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  m_dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_byteen(st_byteen),
    .st_ready(st_ready), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_ack(mem_ack),
    .empty(empty)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_merge();
`ifdef STORE_MERGE_EN
    return q.size() > 1
        && q[q.size()-1].addr[31:2] == st_addr[31:2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    bit hit = 1'b0;
    logic [31:0] ea = '0, ed = '0;
    logic [3:0]  eb = '0;
    foreach (q[i])
      if (q[i].addr[31:2] == ld_addr[31:2]) hit = 1'b1;
    if (q.size() != 0) begin
      ea = {q[0].addr[31:2], 2'b00};
      ed = q[0].data;
      eb = q[0].be;
    end
    chk("mem_req", mem_req, q.size() != 0);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_byteen", mem_byteen, eb);
    chk("empty", empty, q.size() == 0);
    chk("ld_hit", ld_hit, hit);
    chk("st_ready", st_ready, (q.size() < DEPTH) || m_merge());
  endtask

  task automatic tick();
    bit wr, mg, alloc, pop;
    ent_t e;
    @(negedge clk);
    check_all();
    wr    = st_valid && st_byteen != 4'b0000;
    mg    = wr && m_merge();
    alloc = wr && !mg && q.size() < DEPTH;
    pop   = mem_ack && q.size() != 0;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (mg) begin
        e = q[q.size()-1];
        for (int b = 0; b < 4; b++)
          if (st_byteen[b]) e.data[8*b +: 8] = st_wdata[8*b +: 8];
        e.be = e.be | st_byteen;
        q[q.size()-1] = e;
      end
      if (pop) void'(q.pop_front());
      if (alloc) q.push_back('{st_addr, st_wdata, st_byteen});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic ack);
    st_valid  = v;
    st_addr   = a;
    st_wdata  = d;
    st_byteen = be;
    mem_ack   = ack;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_ready"}, st_ready, 1'b1);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_hit"}, ld_hit, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] a2, d2;
    logic [3:0]  b2;
    reset = 1'b1;
    ld_addr = '0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_check("rst0");
    reset = 1'b0;
    tick();

    // single store, stalled ack, then one ack
    drive(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t2_req", mem_req, 1'b1);
    chk("t2_addr", mem_addr, 32'h1000);
    chk("t2_data", mem_wdata, 32'hDEADBEEF);
    repeat (3) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_req_drop", mem_req, 1'b0);
    chk("t2_empty", empty, 1'b1);

    // fill to full, overflow push ignored, back-to-back drain
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 0);
      tick();
    end
    chk("t3_full", st_ready, 1'b0);
    drive(1, 32'h20, 32'h55, 4'hF, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", mem_addr, 32'h10 + 32'(4*i));
      tick();
    end
    mem_ack = 1'b0;
    chk("t3_done", mem_req, 1'b0);

    // zero byte-enable is a no-op
    drive(1, 32'h500, 32'h1, 4'h0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("t4_req", mem_req, 1'b0);
    chk("t4_empty", empty, 1'b1);

    // load-hit on word address
    drive(1, 32'h2003, 32'hAB000000, 4'h8, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    ld_addr = 32'h2000;
    #1 chk("t5_hit", ld_hit, 1'b1);
    ld_addr = 32'h2004;
    #1 chk("t5_nohit", ld_hit, 1'b0);
    ld_addr = 32'h2000;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5_after", ld_hit, 1'b0);

    // merge (or not) of two stores into the same word
    drive(1, 32'h3000, 32'h33333333, 4'hF, 0);
    tick();
    drive(1, 32'h4000, 32'h00000011, 4'h1, 0);
    tick();
    drive(1, 32'h4001, 32'h00002200, 4'h2, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    n = 0;
    a2 = '0; d2 = '0; b2 = '0;
    for (int k = 0; k < 10; k++) begin
      if (!mem_req) break;
      if (n == 1) begin
        a2 = mem_addr; d2 = mem_wdata; b2 = mem_byteen;
      end
      n++;
      tick();
    end
    mem_ack = 1'b0;
    chk("t6_addr2", a2, 32'h4000);
`ifdef STORE_MERGE_EN
    chk("t6_drains", n, 2);
    chk("t6_data2", d2[15:0], 16'h2211);
    chk("t6_be2", b2, 4'h3);
`else
    chk("t6_drains", n, 3);
    chk("t6_data2", d2[15:0], 16'h0011);
    chk("t6_be2", b2, 4'h1);
`endif

    // randomized traffic with a reset dropped in mid-handshake
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        drive(1, 32'h180, 32'h77, 4'hF, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        reset_check("rst_mid");
        q.delete();
        tick();
        reset = 1'b0;
      end
      drive($urandom_range(0, 9) < 6,
            32'h100 + 32'(4*$urandom_range(0, 3))
                    + 32'($urandom_range(0, 3)),
            $urandom,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < ((i % 80) < 40 ? 25 : 80));
      ld_addr = 32'h100 + 32'(4*$urandom_range(0, 4));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
